fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's FIFO among NREQ requesters. Each requester uses a valid/ready stream.
- Grants one requester at a time in round-robin order. A grant holds for a burst that ends on last or at BURST_MAX beats.
- Throttles on the FIFO full / almost-full flags. Drives the FIFO write enable and write data from registers.
- Sits in the FIFO write-clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; matches the FIFO WIDTH.
- BURST_MAX, 4, maximum beats per grant (1..16).
- IDLE_TIMEOUT, 8, stall cycles before a forced burst end (optional feature only).

Ports:
- i_clk  in  1  clock (FIFO write clock).
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NREQ  per-requester beat valid.
- i_req_last  in  NREQ  per-requester end-of-burst marker, qualified by valid.
- i_req_data  in  NREQ*WIDTH  requester r data in bits [r*WIDTH +: WIDTH].
- o_req_ready  out  NREQ  per-requester ready; one-hot or zero.
- i_fifo_full  in  1  FIFO full flag.
- i_fifo_almost_full  in  1  FIFO almost-full flag.
- o_fifo_wr_en  out  1  registered FIFO write enable.
- o_fifo_wr_data  out  WIDTH  registered FIFO write data.
- o_grant  out  NREQ  registered one-hot current grant.
- o_busy  out  1  high while in BURST.

Behaviour:
- Reset values, asynchronous on i_rst_n low:
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - o_grant=0, o_fifo_wr_en=0, o_fifo_wr_data=0, o_busy=0.
  - o_req_ready is combinational, so it is 0 during reset.
- States:
  - IDLE: if any i_req_valid is set, pick the first set bit searching from rr_ptr upward with wrap. Load o_grant with that bit, set beat_cnt=0, go to BURST. No beat is accepted in IDLE.
  - BURST: o_req_ready[g] = o_grant[g] & ~i_fifo_full & ~i_fifo_almost_full. A beat transfers when valid[g] & ready[g].
  - On transfer:
    - o_fifo_wr_en<=1 next cycle, o_fifo_wr_data<=i_req_data[g] next cycle. Latency is exactly 1 cycle.
    - beat_cnt increments.
  - Cycles with no transfer set o_fifo_wr_en<=0.
  - Burst end, evaluated on a transfer: i_req_last[g]=1 or beat_cnt==BURST_MAX-1.
  - At burst end:
    - rr_ptr<=(g+1) mod NREQ.
    - o_grant<=0, state<=IDLE.
    - Minimum one IDLE cycle between bursts; no back-to-back grant.
- Flow control:
  - Integrators program the FIFO almost-full limit so that it asserts with at least 2 free entries. This covers the registered write in flight plus the 1-cycle flag lag.
  - The arbiter never presents o_fifo_wr_en while i_fifo_full was high on the accepting cycle.
- Stalls:
  - If valid[g] drops mid-burst, the grant is held indefinitely (without the optional feature).
  - A stall does not advance beat_cnt.
- Other requesters' valid bits are ignored during BURST. Their ready is 0, and their data is not sampled.
- Simultaneous requests in IDLE: exactly one grant, per rr_ptr order.
- A single requester with continuous traffic re-wins after each IDLE gap.
- Reset mid-burst: immediate return to reset values. A pending o_fifo_wr_en is cleared, and that beat is lost by design.
- Widths:
  - beat_cnt is clog2(BURST_MAX)+1 bits.
  - rr_ptr is clog2(NREQ) bits, with explicit modulo for non-power-of-2 NREQ.

Optional Feature:
- Macro FIFO_WR_ARB_WATCHDOG_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles with valid[g]=0 and resets on any transfer.
  - Reaching IDLE_TIMEOUT forces burst end: rr_ptr advances, return to IDLE, no FIFO write.
  - Cycles with valid[g]=1 but ready low (FIFO full) do not count.
- Undefined: no counter; grant held until last or BURST_MAX.

Decomposition:
- Package fifo_arb_pkg holds:
  - state typedef (IDLE, BURST).
  - default parameter constants.
  - a function for width of beat_cnt.
- Sub-module rr_picker: combinational round-robin priority pick (req vector, rr_ptr -> one-hot, any). Instantiated once.

Test Plan:
- Reset, then requester 1 sends 3 beats 0xA1,0xA2,0xA3 with last on the third:
  - grant=0010 one cycle after valid.
  - FIFO writes 0xA1..0xA3 on consecutive cycles, each 1 cycle after acceptance.
  - Then IDLE, rr_ptr=2.
- All 4 requesters valid continuously, no last, BURST_MAX=4:
  - grants rotate 0,1,2,3,0.
  - each grant writes exactly 4 beats, separated by one idle cycle.
- i_fifo_almost_full raised mid-burst after beat 2 for 5 cycles: ready=0, no writes; resumes with beat 3; beat_cnt is not corrupted.
- Requester 2 drops valid for 20 cycles mid-burst:
  - without the macro, the grant stays 0100.
  - with FIFO_WR_ARB_WATCHDOG_EN and IDLE_TIMEOUT=8, the burst ends after 8 cycles and the grant moves to requester 3.
- i_rst_n asserted while o_fifo_wr_en=1 mid-burst: all outputs 0 immediately (async); first grant after release goes to requester 0 if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the beat-counter width helper.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NREQ         = 4;
   localparam int DEF_WIDTH        = 8;
   localparam int DEF_BURST_MAX    = 4;
   localparam int DEF_IDLE_TIMEOUT = 8;

   // One extra bit so the counter can hold BURST_MAX itself after the final beat.
   function automatic int beat_cnt_w(input int burst_max);
      return $clog2(burst_max) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams, FIFO flags and FIFO write port of the arbiter.
// Handshake: a beat moves on a clock edge where i_req_valid[r] and o_req_ready[r] are both high;
// i_req_last/i_req_data are only meaningful while valid is high, and valid must not depend on ready.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);
   logic [NREQ-1:0]       i_req_valid;
   logic [NREQ-1:0]       i_req_last;
   logic [NREQ*WIDTH-1:0] i_req_data;
   logic [NREQ-1:0]       o_req_ready;
   logic                  i_fifo_full;
   logic                  i_fifo_almost_full;
   logic                  o_fifo_wr_en;
   logic [WIDTH-1:0]      o_fifo_wr_data;
   logic [NREQ-1:0]       o_grant;
   logic                  o_busy;

   modport slave (
      input  i_req_valid, i_req_last, i_req_data, i_fifo_full, i_fifo_almost_full,
      output o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_grant, o_busy
   );

   modport master (
      output i_req_valid, i_req_last, i_req_data, i_fifo_full, i_fifo_almost_full,
      input  o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_grant, o_busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
// Returns a one-hot pick and an any-request flag.
module rr_picker #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_pick,
   output logic             o_any
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      o_pick = '0;
      found  = 1'b0;
      idx    = '0;
      // Explicit modulo keeps the wrap correct for non-power-of-2 NREQ.
      for (int i = 0; i < NREQ; i++) begin
         idx = PTR_W'((int'(i_ptr) + i) % NREQ);
         if (!found && i_req[idx]) begin
            o_pick[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters.
// Optional burst watchdog: define FIFO_WR_ARB_WATCHDOG_EN to end bursts stalled for IDLE_TIMEOUT cycles.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ         = DEF_NREQ,
   parameter int WIDTH        = DEF_WIDTH,
   parameter int BURST_MAX    = DEF_BURST_MAX,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input logic              i_clk,
   input logic              i_rst_n,
   fifo_wr_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = beat_cnt_w(BURST_MAX);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic             wr_en_q, wr_en_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;

   logic [NREQ-1:0]  pick;
   logic             pick_any;
   logic [NREQ-1:0]  ready;
   logic             xfer;
   logic             sel_last;
   logic             burst_end;
   logic [PTR_W-1:0] g_idx, g_next;
   logic [WIDTH-1:0] req_data_a [NREQ];
   logic [WIDTH-1:0] sel_data;

`ifdef FIFO_WR_ARB_WATCHDOG_EN
   localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);
   logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
   logic               sel_valid;
   assign sel_valid = |(bus.i_req_valid & grant_q);
`endif

   rr_picker #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_picker (
      .i_req  (bus.i_req_valid),
      .i_ptr  (rr_ptr_q),
      .o_pick (pick),
      .o_any  (pick_any)
   );

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_data_a[i] = bus.i_req_data[i*WIDTH +: WIDTH];
         if (grant_q[i]) g_idx = PTR_W'(i);
      end
   end

   assign g_next   = (g_idx == PTR_W'(NREQ - 1)) ? '0 : g_idx + PTR_W'(1);
   assign sel_data = req_data_a[g_idx];
   assign sel_last = |(bus.i_req_last & grant_q);

   // Both flags gate ready so the registered write never lands on a full FIFO.
   assign ready = (state_q == BURST) ?
                  (grant_q & {NREQ{~bus.i_fifo_full & ~bus.i_fifo_almost_full}}) : '0;
   assign xfer  = |(bus.i_req_valid & ready);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      grant_d    = grant_q;
      wr_en_d    = 1'b0;
      wr_data_d  = wr_data_q;
      burst_end  = 1'b0;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
      stall_cnt_d = stall_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d    = pick;
               beat_cnt_d = '0;
               state_d    = BURST;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
               stall_cnt_d = '0;
`endif
            end
         end
         BURST: begin
            if (xfer) begin
               wr_en_d    = 1'b1;
               wr_data_d  = sel_data;
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (sel_last || (beat_cnt_q == CNT_W'(BURST_MAX - 1))) burst_end = 1'b1;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
               stall_cnt_d = '0;
`endif
            end
`ifdef FIFO_WR_ARB_WATCHDOG_EN
            // Only an absent requester counts as a stall; FIFO backpressure does not.
            else if (!sel_valid) begin
               if (stall_cnt_q == STALL_W'(IDLE_TIMEOUT - 1)) burst_end = 1'b1;
               else stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
`endif
            if (burst_end) begin
               rr_ptr_d = g_next;
               grant_d  = '0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         grant_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         grant_q    <= grant_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
`ifdef FIFO_WR_ARB_WATCHDOG_EN
         stall_cnt_q <= stall_cnt_d;
`endif
      end
   end

   assign bus.o_req_ready    = ready;
   assign bus.o_fifo_wr_en   = wr_en_q;
   assign bus.o_fifo_wr_data = wr_data_q;
   assign bus.o_grant        = grant_q;
   assign bus.o_busy         = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single burst, round-robin rotation, almost-full throttle,
// mid-burst stall and asynchronous reset mid-burst.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NREQ         = 4;
   localparam int WIDTH        = 8;
   localparam int BURST_MAX    = 4;
   localparam int IDLE_TIMEOUT = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

   fifo_wr_arbiter #(
      .NREQ         (NREQ),
      .WIDTH        (WIDTH),
      .BURST_MAX    (BURST_MAX),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic l, input logic [7:0] d);
      bus.i_req_valid[r]               = v;
      bus.i_req_last[r]                = l;
      bus.i_req_data[r*WIDTH +: WIDTH] = d;
   endtask

   task automatic check_write(input string tag, input logic [7:0] d);
      check_eq({tag, "_wr_en"}, 32'(bus.o_fifo_wr_en), 32'd1);
      check_eq({tag, "_wr_data"}, 32'(bus.o_fifo_wr_data), 32'(d));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int order [4] = '{2, 3, 0, 1};

      bus.i_req_valid        = '0;
      bus.i_req_last         = '0;
      bus.i_req_data         = '0;
      bus.i_fifo_full        = 1'b0;
      bus.i_fifo_almost_full = 1'b0;

      // reset values
      repeat (2) tick();
      check_eq("rst_grant", 32'(bus.o_grant), 32'h0);
      check_eq("rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
      check_eq("rst_wr_data", 32'(bus.o_fifo_wr_data), 32'h0);
      check_eq("rst_busy", 32'(bus.o_busy), 32'h0);
      check_eq("rst_ready", 32'(bus.o_req_ready), 32'h0);
      rst_n = 1'b1;

      // requester 1: three beats, last on the third
      set_req(1, 1'b1, 1'b0, 8'hA1);
      tick();
      check_eq("s1_grant", 32'(bus.o_grant), 32'b0010);
      check_eq("s1_busy", 32'(bus.o_busy), 32'h1);
      check_eq("s1_ready", 32'(bus.o_req_ready), 32'b0010);
      check_eq("s1_no_wr_in_grant", 32'(bus.o_fifo_wr_en), 32'h0);
      for (int k = 0; k < 3; k++) begin
         set_req(1, 1'b1, (k == 2), 8'(8'hA1 + k));
         tick();
         check_write("s1_beat", 8'(8'hA1 + k));
      end
      check_eq("s1_end_grant", 32'(bus.o_grant), 32'h0);
      check_eq("s1_end_busy", 32'(bus.o_busy), 32'h0);
      set_req(1, 1'b0, 1'b0, 8'h00);

      // all requesters continuously valid: rotation resumes at rr_ptr=2
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 1'b0, 8'(8'hB0 + r));
      for (int b = 0; b < 4; b++) begin
         tick();
         check_eq("s2_grant", 32'(bus.o_grant), 32'(1 << order[b]));
         check_eq("s2_gap_no_wr", 32'(bus.o_fifo_wr_en), 32'h0);
         for (int k = 0; k < BURST_MAX; k++) begin
            tick();
            check_write("s2_beat", 8'(8'hB0 + order[b]));
         end
         check_eq("s2_burst_end", 32'(bus.o_grant), 32'h0);
      end
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 1'b0, 8'h00);
      tick();
      check_eq("s2_idle_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
      check_eq("s2_idle_grant", 32'(bus.o_grant), 32'h0);

      // almost-full throttle after two beats of requester 2
      set_req(2, 1'b1, 1'b0, 8'hC0);
      tick();
      check_eq("s3_grant", 32'(bus.o_grant), 32'b0100);
      tick();
      check_write("s3_beat0", 8'hC0);
      set_req(2, 1'b1, 1'b0, 8'hC1);
      tick();
      check_write("s3_beat1", 8'hC1);
      set_req(2, 1'b1, 1'b0, 8'hC2);
      bus.i_fifo_almost_full = 1'b1;
      #1;
      check_eq("s3_af_ready", 32'(bus.o_req_ready), 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("s3_af_no_wr", 32'(bus.o_fifo_wr_en), 32'h0);
         check_eq("s3_af_grant", 32'(bus.o_grant), 32'b0100);
      end
      bus.i_fifo_almost_full = 1'b0;
      #1;
      check_eq("s3_resume_ready", 32'(bus.o_req_ready), 32'b0100);
      tick();
      check_write("s3_beat2", 8'hC2);
      set_req(2, 1'b1, 1'b0, 8'hC3);
      tick();
      check_write("s3_beat3", 8'hC3);
      check_eq("s3_end_grant", 32'(bus.o_grant), 32'h0);
      set_req(2, 1'b0, 1'b0, 8'h00);

      // requester 2 stalls mid-burst while requester 3 waits
      set_req(2, 1'b1, 1'b0, 8'hD0);
      tick();
      check_eq("s4_grant", 32'(bus.o_grant), 32'b0100);
      tick();
      check_write("s4_beat0", 8'hD0);
      set_req(2, 1'b0, 1'b0, 8'h00);
      set_req(3, 1'b1, 1'b0, 8'hE0);
`ifdef FIFO_WR_ARB_WATCHDOG_EN
      for (int k = 0; k < IDLE_TIMEOUT - 1; k++) begin
         tick();
         check_eq("s4_wd_hold", 32'(bus.o_grant), 32'b0100);
      end
      tick();
      check_eq("s4_wd_end_grant", 32'(bus.o_grant), 32'h0);
      check_eq("s4_wd_no_wr", 32'(bus.o_fifo_wr_en), 32'h0);
      tick();
      check_eq("s4_wd_next_grant", 32'(bus.o_grant), 32'b1000);
      set_req(3, 1'b1, 1'b1, 8'hE0);
      tick();
      check_write("s4_wd_e0", 8'hE0);
      set_req(3, 1'b0, 1'b0, 8'h00);
`else
      for (int k = 0; k < 20; k++) begin
         tick();
         check_eq("s4_stall_grant", 32'(bus.o_grant), 32'b0100);
         check_eq("s4_stall_ready", 32'(bus.o_req_ready), 32'b0100);
         check_eq("s4_stall_no_wr", 32'(bus.o_fifo_wr_en), 32'h0);
      end
      set_req(2, 1'b1, 1'b1, 8'hD1);
      tick();
      check_write("s4_beat1", 8'hD1);
      check_eq("s4_end_grant", 32'(bus.o_grant), 32'h0);
      set_req(2, 1'b0, 1'b0, 8'h00);
      set_req(3, 1'b0, 1'b0, 8'h00);
`endif
      tick();
      check_eq("s4_idle_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);

      // asynchronous reset while a write is pending
      set_req(3, 1'b1, 1'b0, 8'hF0);
      tick();
      check_eq("s5_grant", 32'(bus.o_grant), 32'b1000);
      tick();
      check_write("s5_beat0", 8'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("s5_rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
      check_eq("s5_rst_wr_data", 32'(bus.o_fifo_wr_data), 32'h0);
      check_eq("s5_rst_grant", 32'(bus.o_grant), 32'h0);
      check_eq("s5_rst_busy", 32'(bus.o_busy), 32'h0);
      check_eq("s5_rst_ready", 32'(bus.o_req_ready), 32'h0);
      set_req(0, 1'b1, 1'b0, 8'h50);
      repeat (2) tick();
      check_eq("s5_held_grant", 32'(bus.o_grant), 32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("s5_post_rst_grant", 32'(bus.o_grant), 32'b0001);
      check_eq("s5_post_rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
